// File: rtl/pipelined_csel_adder_if.sv
// Stream bundle for the pipelined carry-select adder: operand beat in, result beat out.
interface pipelined_csel_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: GPS carry-select groups resolved per stage,
// one result per cycle, whole-pipe stall on output backpressure.
module pipelined_csel_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4,
  parameter int GPS   = 1
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_csel_adder_if.slave bus
);
  localparam int NG = WIDTH / GROUP;
  localparam int NS = NG / GPS;

  generate
    if (WIDTH % GROUP != 0) begin : g_bad_width
      $error("WIDTH must be a multiple of GROUP");
    end
    if (NG % GPS != 0) begin : g_bad_gps
      $error("WIDTH/GROUP must be a multiple of GPS");
    end
  endgenerate

  // Both carry-in candidates are formed, the incoming carry only drives the final mux.
  function automatic logic [GROUP:0] csel_group(input logic [GROUP-1:0] x,
                                                input logic [GROUP-1:0] y,
                                                input logic             ci);
    logic [GROUP:0] s0;
    logic [GROUP:0] s1;
    s0 = {1'b0, x} + {1'b0, y};
    s1 = {1'b0, x} + {1'b0, y} + {{GROUP{1'b0}}, 1'b1};
    return ci ? s1 : s0;
  endfunction

  logic             vld_q [NS];
  logic             vld_d [NS];
  logic [WIDTH-1:0] sum_q [NS];
  logic [WIDTH-1:0] sum_d [NS];
  logic [WIDTH-1:0] a_q   [NS];
  logic [WIDTH-1:0] a_d   [NS];
  logic [WIDTH-1:0] b_q   [NS];
  logic [WIDTH-1:0] b_d   [NS];
  logic             c_q   [NS];
  logic             c_d   [NS];
  logic             ovf_q;
  logic             ovf_d;

  logic             st_v   [NS];
  logic [WIDTH-1:0] st_a   [NS];
  logic [WIDTH-1:0] st_b   [NS];
  logic [WIDTH-1:0] st_sum [NS];
  logic             st_c   [NS];

  logic             stall;

  assign stall         = vld_q[NS-1] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld_q[NS-1];
  assign bus.sum       = sum_q[NS-1];
  assign bus.cout      = c_q[NS-1];
  assign bus.ovf       = ovf_q;

  // Stage inputs: stage 0 takes the accepted beat (B pre-inverted for subtract), others the previous register.
  always_comb begin
    st_v[0]   = bus.in_valid;
    st_a[0]   = bus.a;
    st_b[0]   = bus.sub ? ~bus.b : bus.b;
    st_sum[0] = '0;
    st_c[0]   = bus.sub | bus.cin;
    for (int s = 1; s < NS; s++) begin
      st_v[s]   = vld_q[s-1];
      st_a[s]   = a_q[s-1];
      st_b[s]   = b_q[s-1];
      st_sum[s] = sum_q[s-1];
      st_c[s]   = c_q[s-1];
    end
  end

  always_comb begin
    logic [WIDTH-1:0] acc;
    logic             c;
    logic [GROUP:0]   grp;
    acc = '0;
    c   = 1'b0;
    grp = '0;
    for (int s = 0; s < NS; s++) begin
      acc = st_sum[s];
      c   = st_c[s];
      for (int g = 0; g < GPS; g++) begin
        grp = csel_group(st_a[s][(s*GPS+g)*GROUP +: GROUP],
                         st_b[s][(s*GPS+g)*GROUP +: GROUP], c);
        acc[(s*GPS+g)*GROUP +: GROUP] = grp[GROUP-1:0];
        c = grp[GROUP];
      end
      vld_d[s] = st_v[s];
      sum_d[s] = acc;
      c_d[s]   = c;
      a_d[s]   = (s == NS-1) ? '0 : st_a[s];
      b_d[s]   = (s == NS-1) ? '0 : st_b[s];
    end
    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    ovf_d = sum_d[NS-1][WIDTH-1] ^ st_a[NS-1][WIDTH-1] ^ st_b[NS-1][WIDTH-1] ^ c_d[NS-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        vld_q[s] <= 1'b0;
        sum_q[s] <= '0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        c_q[s]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int s = 0; s < NS; s++) begin
        vld_q[s] <= vld_d[s];
        sum_q[s] <= sum_d[s];
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        c_q[s]   <= c_d[s];
      end
      ovf_q <= ovf_d;
    end
  end
endmodule
